// File: rtl/a26_paddle_pkg.sv
// Shared types and threshold helper for the TIA paddle pot responder.
// Optional position filter is enabled by defining PADDLE_LPF_EN.
package a26_paddle_pkg;

  typedef enum logic [1:0] {
    POT_DUMPED,
    POT_CHARGING,
    POT_CHARGED
  } pot_state_t;

  localparam int unsigned CNT_W_DEF = 10;

  function automatic logic [31:0] pot_thr(
    input logic [7:0]  pos,
    input int unsigned min,
    input int unsigned num,
    input int unsigned shift,
    input int unsigned cw
  );
    logic [31:0] raw;
    logic [31:0] lim;
    raw = min + ((32'(pos) * num) >> shift);
    lim = (32'd1 << cw) - 32'd1;
    return (raw > lim) ? lim : raw;
  endfunction

endpackage

// File: rtl/a26_paddle_channel.sv
// One pot channel: dump/charge FSM, line counter and latched threshold.
// PADDLE_LPF_EN adds a per-channel position low-pass filter.
module a26_paddle_channel
  import a26_paddle_pkg::*;
#(
  parameter int unsigned MIN_LINES   = 2,
  parameter int unsigned SCALE_NUM   = 3,
  parameter int unsigned SCALE_SHIFT = 1,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce_line,
  input  logic       dump,
  input  logic [7:0] pos,
  output logic       pad_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pot_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] thr_q, thr_d;
  logic             pad_q, pad_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] thr_new;
  logic [7:0]       thr_pos;

`ifdef PADDLE_LPF_EN
  logic [7:0]        filt_q, filt_d;
  logic [7:0]        filt_new;
  logic signed [8:0] diff;
  logic signed [8:0] step;

  // Move the filter a quarter of the way toward the live position
  always_comb begin
    diff     = $signed({1'b0, pos}) - $signed({1'b0, filt_q});
    step     = diff >>> 2;
    filt_new = filt_q + 8'(step);
    thr_pos  = filt_new;
  end
`else
  assign thr_pos = pos;
`endif

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign thr_new = CNT_W'(pot_thr(thr_pos, MIN_LINES, SCALE_NUM,
                                  SCALE_SHIFT, CNT_W));

  // Next-state: dump overrides everything, else charge per scanline
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    thr_d   = thr_q;
    pad_d   = pad_q;
`ifdef PADDLE_LPF_EN
    filt_d  = filt_q;
`endif
    if (dump) begin
      state_d = POT_DUMPED;
      cnt_d   = '0;
      pad_d   = 1'b0;
    end else begin
      unique case (state_q)
        POT_DUMPED: begin
          state_d = POT_CHARGING;
          cnt_d   = '0;
          pad_d   = 1'b0;
          thr_d   = thr_new;
`ifdef PADDLE_LPF_EN
          filt_d  = filt_new;
`endif
        end
        POT_CHARGING: begin
          if (ce_line) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= thr_q) begin
              state_d = POT_CHARGED;
              pad_d   = 1'b1;
            end
          end
        end
        POT_CHARGED: pad_d = 1'b1;
        default: begin
          state_d = POT_DUMPED;
          cnt_d   = '0;
          pad_d   = 1'b0;
        end
      endcase
    end
  end

  // Channel state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= POT_DUMPED;
      cnt_q   <= '0;
      thr_q   <= '0;
      pad_q   <= 1'b0;
`ifdef PADDLE_LPF_EN
      filt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      thr_q   <= thr_d;
      pad_q   <= pad_d;
`ifdef PADDLE_LPF_EN
      filt_q  <= filt_d;
`endif
    end
  end

  assign pad_out = pad_q;

endmodule

// File: rtl/a26_paddle_pot.sv
// TIA paddle pot responder: NUM_PADS independent RC-pot emulators.
// Define PADDLE_LPF_EN to low-pass filter each paddle position.
module a26_paddle_pot
  import a26_paddle_pkg::*;
#(
  parameter int unsigned NUM_PADS    = 4,
  parameter int unsigned MIN_LINES   = 2,
  parameter int unsigned SCALE_NUM   = 3,
  parameter int unsigned SCALE_SHIFT = 1,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce_line,
  input  logic                  dump,
  input  logic [NUM_PADS*8-1:0] pos,
  output logic [NUM_PADS-1:0]   pad_out
);

  for (genvar i = 0; i < NUM_PADS; i++) begin : g_ch
    a26_paddle_channel #(
      .MIN_LINES  (MIN_LINES),
      .SCALE_NUM  (SCALE_NUM),
      .SCALE_SHIFT(SCALE_SHIFT),
      .CNT_W      (CNT_W)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .ce_line(ce_line),
      .dump   (dump),
      .pos    (pos[8*i +: 8]),
      .pad_out(pad_out[i])
    );
  end

endmodule

// File: tb/tb_a26_paddle_pot.sv
// Scoreboard bench for a26_paddle_pot (default parameters).
// Define PADDLE_LPF_EN to also exercise the position filter.
module tb_a26_paddle_pot;
  import a26_paddle_pkg::*;

  localparam int NP = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            ce_line;
  logic            dump;
  logic [NP*8-1:0] pos;
  logic [NP-1:0]   pad_out;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int ch;
    int exp;
  } exp_t;

  exp_t sb_q[$];
  int   filt_m[NP];

  a26_paddle_pot u_dut (
    .clk    (clk),
    .reset  (reset),
    .ce_line(ce_line),
    .dump   (dump),
    .pos    (pos),
    .pad_out(pad_out)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic int model_thr(int p);
    int t;
    t = 2 + (p * 3) / 2;
    return (t > 1023) ? 1023 : t;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse;
    ce_line = 1'b1;
    tick;
    ce_line = 1'b0;
    repeat (7) tick;
  endtask

  task automatic model_release(input logic [NP*8-1:0] pv);
    int p;
    int d;
    int st;
    for (int ch = 0; ch < NP; ch++) begin
      p = int'(pv[8*ch +: 8]);
`ifdef PADDLE_LPF_EN
      d  = p - filt_m[ch];
      st = (d >= 0) ? d / 4 : -((-d + 3) / 4);
      filt_m[ch] = (filt_m[ch] + st) & 255;
      p  = filt_m[ch];
`else
      d  = 0;
      st = d;
`endif
      sb_q.push_back('{ch, model_thr(p)});
    end
  endtask

  task automatic release_pads(input logic [NP*8-1:0] pv);
    dump = 1'b1;
    pos  = pv;
    repeat (2) tick;
    model_release(pv);
    dump = 1'b0;
    tick;
    checks++;
    if (pad_out !== '0) begin
      failures++;
      $display("FAIL release_low pad_out=%b expected=0000", pad_out);
    end
  endtask

  task automatic collect(input int budget, input int change_at,
                         input logic [NP*8-1:0] pos2, input string nm);
    int   rise[NP];
    bit   all;
    exp_t e;
    for (int ch = 0; ch < NP; ch++) rise[ch] = -1;
    for (int p = 1; p <= budget; p++) begin
      if (p == change_at + 1) pos = pos2;
      pulse;
      all = 1'b1;
      for (int ch = 0; ch < NP; ch++) begin
        if (rise[ch] < 0) begin
          if (pad_out[ch]) rise[ch] = p;
          else all = 1'b0;
        end
      end
      if (all) break;
    end
    for (int k = 0; k < NP; k++) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL %s scoreboard_empty actual=none expected=entry", nm);
      end else begin
        e = sb_q.pop_front();
        if (rise[e.ch] !== e.exp) begin
          failures++;
          $display("FAIL %s ch%0d rise_pulse=%0d expected=%0d",
                   nm, e.ch, rise[e.ch], e.exp);
        end
      end
    end
  endtask

  task automatic check_ch0_dumped(input string nm);
    checks++;
    if (pad_out[0] !== 1'b0 ||
        u_dut.g_ch[0].u_ch.state_q !== POT_DUMPED ||
        u_dut.g_ch[0].u_ch.cnt_q !== 10'd0) begin
      failures++;
      $display("FAIL %s pad=%b state=%0d cnt=%0d expected pad=0 state=0 cnt=0",
               nm, pad_out[0], u_dut.g_ch[0].u_ch.state_q,
               u_dut.g_ch[0].u_ch.cnt_q);
    end
  endtask

  task automatic test_reset;
    reset   = 1'b1;
    ce_line = 1'b0;
    dump    = 1'b0;
    pos     = 32'hFFFF_FFFF;
    repeat (3) tick;
    for (int ch = 0; ch < NP; ch++) filt_m[ch] = 0;
    sb_q.delete();
    check_ch0_dumped("reset");
    checks++;
    if (pad_out !== '0 || u_dut.g_ch[0].u_ch.thr_q !== 10'd0) begin
      failures++;
      $display("FAIL reset_all pad_out=%b thr=%0d expected 0000 thr=0",
               pad_out, u_dut.g_ch[0].u_ch.thr_q);
    end
    dump  = 1'b1;
    tick;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    release_pads({8'd10, 8'd64, 8'd200, 8'd100});
    collect(400, -1, '0, "basic");
  endtask

  task automatic test_range;
    release_pads({8'd200, 8'd37, 8'd128, 8'd0});
    collect(400, -1, '0, "range_low");
    release_pads({8'd0, 8'd1, 8'd254, 8'd255});
    collect(400, -1, '0, "range_high");
  endtask

  task automatic test_dump_mid;
    int n;
    release_pads(32'h6464_6464);
    n = (sb_q[0].exp - 1 < 50) ? sb_q[0].exp - 1 : 50;
    repeat (n) pulse;
    checks++;
    if (pad_out[0] !== 1'b0) begin
      failures++;
      $display("FAIL dump_mid_pre pad=%b expected=0", pad_out[0]);
    end
    sb_q.delete();
    dump = 1'b1;
    tick;
    check_ch0_dumped("dump_mid");
    repeat (5) pulse;
    check_ch0_dumped("dump_held");
    release_pads(32'h6464_6464);
    collect(400, -1, '0, "dump_rerelease");
  endtask

  task automatic test_pos_change;
    release_pads(32'h6464_6464);
    collect(400, 20, 32'h0A0A_0A0A, "pos_change");
  endtask

  task automatic test_coincident;
    int n;
    release_pads(32'h6464_6464);
    n = sb_q[0].exp - 1;
    repeat (n) pulse;
    checks++;
    if (pad_out[0] !== 1'b0) begin
      failures++;
      $display("FAIL coincident_pre pad=%b expected=0", pad_out[0]);
    end
    sb_q.delete();
    ce_line = 1'b1;
    dump    = 1'b1;
    tick;
    ce_line = 1'b0;
    check_ch0_dumped("coincident");
    repeat (7) tick;
    check_ch0_dumped("coincident_after");
  endtask

`ifdef PADDLE_LPF_EN
  task automatic test_lpf;
    test_reset;
    release_pads({8'd0, 8'd0, 8'd0, 8'd255});
    checks++;
    if (u_dut.g_ch[0].u_ch.filt_q !== 8'd63) begin
      failures++;
      $display("FAIL lpf_frame1 filt=%0d expected=63",
               u_dut.g_ch[0].u_ch.filt_q);
    end
    collect(400, -1, '0, "lpf_frame1");
    release_pads({8'd0, 8'd0, 8'd0, 8'd255});
    checks++;
    if (u_dut.g_ch[0].u_ch.filt_q !== 8'd111) begin
      failures++;
      $display("FAIL lpf_frame2 filt=%0d expected=111",
               u_dut.g_ch[0].u_ch.filt_q);
    end
    collect(400, -1, '0, "lpf_frame2");
    release_pads({8'd0, 8'd0, 8'd0, 8'd255});
    collect(400, -1, '0, "lpf_frame3");
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_range;
    test_dump_mid;
    test_pos_change;
    test_coincident;
`ifdef PADDLE_LPF_EN
    test_lpf;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
